// File: rtl/huffman_stream_merger.sv
// huffman_stream_merger
// Merges CH per-row Huffman code streams into one MSB-first bitstream packed into
// OUT_W-bit words. Each channel has its own FIFO; channels are drained round-robin,
// one segment (terminated by a done beat) at a time. A frame ends on the done+eop
// beat of the last channel, after which the remaining bits are flushed and the
// final word is padded.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     per-channel beat handshake (in_ready = FIFO not full)
//   in_code/in_size       per-channel right-aligned code and its length
//   in_eop/in_done        per-channel end-of-picture / end-of-segment markers
//   out_valid/out_ready   output word handshake
//   out_data              packed word, first bit at MSB
//   out_sop/out_eop       first / last word of a frame
//   ovf_err               sticky: a beat was presented while in_ready was low
//   frame_cnt             completed frames, wrapping
module huffman_stream_merger #(
    parameter int unsigned CH         = 3,
    parameter int unsigned CODE_W     = 32,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter bit          PAD_ONES   = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CH-1:0]                   in_valid,
    output logic [CH-1:0]                   in_ready,
    input  logic [CH*CODE_W-1:0]            in_code,
    input  logic [CH*$clog2(CODE_W+1)-1:0]  in_size,
    input  logic [CH-1:0]                   in_eop,
    input  logic [CH-1:0]                   in_done,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_W-1:0]                out_data,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic                            ovf_err,
    output logic [15:0]                     frame_cnt
);

    localparam int unsigned SZ_W  = $clog2(CODE_W + 1);
    localparam int unsigned ACC_W = 2 * OUT_W;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned SEL_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned ENT_W = CODE_W + SZ_W + 2;

    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] ACC_CNT = CNT_W'(ACC_W);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH - 1);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    logic                     ready_en_q;
    logic [CH-1:0][ENT_W-1:0] head;
    logic [CH-1:0]            fifo_empty;
    logic [CH-1:0]            fifo_full;
    logic [CH-1:0]            rd_en;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sh;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_sh;
    logic             eop_sent_q, sop_pending_q;
    logic             out_valid_q, out_sop_q, out_eop_q;
    logic [OUT_W-1:0] out_data_q;
    logic             ovf_q;
    logic [15:0]      frame_cnt_q;

    // ---------------- per-channel FIFOs ----------------
    for (genvar g = 0; g < CH; g++) begin : g_fifo
        logic [ENT_W-1:0] mem [FIFO_DEPTH];
        logic [AW:0]      wptr_q, rptr_q;
        logic             wr_en;

        assign fifo_empty[g] = (wptr_q == rptr_q);
        assign fifo_full[g]  = (wptr_q[AW] != rptr_q[AW]) &&
                               (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        // Held low until the first clock after reset release.
        assign in_ready[g]   = ready_en_q && !fifo_full[g];
        assign wr_en         = in_valid[g] && in_ready[g];
        assign head[g]       = mem[rptr_q[AW-1:0]];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wptr_q[AW-1:0]] <= {in_code[g*CODE_W +: CODE_W], in_size[g*SZ_W +: SZ_W],
                                        in_eop[g], in_done[g]};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (wr_en)    wptr_q <= wptr_q + PTR_ONE;
                if (rd_en[g]) rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // ---------------- arbiter ----------------
    logic [ENT_W-1:0]  head_sel;
    logic              sel_empty;
    logic              pop, frame_end;
    logic [CODE_W-1:0] pop_code;
    logic [SZ_W-1:0]   pop_size;
    logic              pop_eop, pop_done;

    always_comb begin
        head_sel  = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                head_sel  = head[i];
                sel_empty = fifo_empty[i];
            end
        end
    end

    assign pop_code  = head_sel[ENT_W-1 -: CODE_W];
    assign pop_size  = head_sel[2 +: SZ_W];
    assign pop_eop   = head_sel[1];
    assign pop_done  = head_sel[0];
    assign pop       = !sel_empty && (acc_cnt_q <= OUT_CNT) && (state_q != StFlush);
    assign frame_end = pop && pop_done && pop_eop && (sel_q == SEL_LAST);

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            rd_en[i] = pop && (sel_q == SEL_W'(i));
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (pop && pop_done) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_ONE;
        end
    end

    // ---------------- word emission ----------------
    logic             want, is_eop, load, out_hs;
    logic [OUT_W-1:0] pad, word;

    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        want   = 1'b0;
        is_eop = 1'b0;
        case (state_q)
            // A word of exactly OUT_W bits is held so eop lands on the true last word.
            StRun:   want = (acc_cnt_q > OUT_CNT);
            StFlush: begin
                want   = !eop_sent_q;
                is_eop = (acc_cnt_q <= OUT_CNT);
            end
            default: ;
        endcase
        load = want && (!out_valid_q || out_ready);
        pad  = (is_eop && PAD_ONES) ? ({OUT_W{1'b1}} >> acc_cnt_q) : '0;
        word = acc_q[ACC_W-1 -: OUT_W] | pad;
    end

    // ---------------- accumulator ----------------
    always_comb begin
        acc_sh = acc_q;
        cnt_sh = acc_cnt_q;
        if (load) begin
            acc_sh = acc_q << OUT_W;
            cnt_sh = (acc_cnt_q > OUT_CNT) ? acc_cnt_q - OUT_CNT : '0;
        end
        acc_d     = acc_sh;
        acc_cnt_d = cnt_sh;
        if (pop) begin
            // MSB-align the code (upper garbage falls off), then drop it after existing bits.
            acc_d     = acc_sh | ((ACC_W'(pop_code) << (ACC_CNT - CNT_W'(pop_size))) >> cnt_sh);
            acc_cnt_d = cnt_sh + CNT_W'(pop_size);
        end
    end

    // ---------------- state machine ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pop) state_d = frame_end ? StFlush : StRun;
            StRun:   if (frame_end) state_d = StFlush;
            StFlush: if (out_hs && out_eop_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q    <= 1'b0;
            sel_q         <= '0;
            state_q       <= StIdle;
            acc_q         <= '0;
            acc_cnt_q     <= '0;
            eop_sent_q    <= 1'b0;
            sop_pending_q <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            ovf_q         <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            ready_en_q <= 1'b1;
            sel_q      <= sel_d;
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;

            if (load && is_eop) begin
                eop_sent_q <= 1'b1;
            end else if (state_q == StFlush && state_d == StIdle) begin
                eop_sent_q <= 1'b0;
            end

            if (load) begin
                sop_pending_q <= 1'b0;
            end else if (state_q == StFlush && state_d == StIdle) begin
                sop_pending_q <= 1'b1;
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= word;
                out_sop_q   <= sop_pending_q;
                out_eop_q   <= is_eop;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (|(in_valid & ~in_ready)) ovf_q <= 1'b1;
            if (out_hs && out_eop_q)     frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign ovf_err   = ovf_q;
    assign frame_cnt = frame_cnt_q;

endmodule
